// File: rtl/mem_access_unit.sv
// MEM-stage load/store to req/ack bus controller: lane placement, byte enables, load align/extend.
// Latency: result in the ack cycle; data_mem_wait high until ack; completed result held in DONE while the pipe is frozen.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              pipe_advance,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              data_mem_wait,
    output logic [31:0]       load_data,
    output logic              access_fault
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access, is_load, misalign, bad_f3, fault, active, ack_ok;
    logic [31:0] shifted, ext;

    always_comb begin
        access   = mem_read | mem_write;
        is_load  = mem_read & ~mem_write;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = (addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        bad_f3 = (funct3 inside {3'b011, 3'b110, 3'b111}) | (mem_write & funct3[2]);
        fault  = access & (misalign | bad_f3);
        // Gating with rst_n drops the request the instant reset asserts, even mid-WAIT.
        active = rst_n & access & ~fault;

        shifted = bus_rdata >> {addr[1:0], 3'b000};
        case (funct3)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase

        bus_req       = active & (state_q != DONE);
        bus_we        = mem_write;
        bus_addr      = {addr[ADDR_W-1:2], 2'b00};
        bus_be        = 4'b1111;
        bus_wdata     = wdata;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    bus_be    = 4'b0001 << addr[1:0];
                    bus_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    bus_be    = 4'b0011 << {addr[1], 1'b0};
                    bus_wdata = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
        ack_ok        = bus_req & bus_ack;
        data_mem_wait = active & ~bus_ack & (state_q != DONE);
        access_fault  = rst_n & fault;

        load_data = 32'h0;
        if (rst_n && !fault) begin
            if (state_q == DONE)
                load_data = rdata_q;
            else if (ack_ok && is_load)
                load_data = ext;
        end

        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE, WAIT: begin
                if (ack_ok) begin
                    rdata_d = is_load ? ext : 32'h0;
                    state_d = pipe_advance ? IDLE : DONE;
                end else if (bus_req) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (pipe_advance)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
